// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter clients: bus widths and the
// region type that selects which client owns a returned word.
package sdram_pkg;
    localparam int ADDR_W   = 24;
    localparam int DATA_W   = 16;
    localparam int REGION_W = 4;
    localparam int WORD_W   = ADDR_W - REGION_W;

    typedef logic [REGION_W-1:0] region_t;

    function automatic region_t region_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: REGION_W];
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head. Push while full is honoured
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        do_pop   = pop && (count_q != CNT_W'(0));
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == CNT_W'(0));
    assign count = count_q;
endmodule

// File: rtl/sdram_read_port.sv
// Read client for the SDRAM arbiter: one command slot, an in-order pending
// address FIFO, address-matched response claiming and a head-age timeout.
module sdram_read_port
    import sdram_pkg::*;
#(
    parameter int      DEPTH   = 4,
    parameter region_t REGION  = 4'h0,
    parameter int      TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [WORD_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [WORD_W-1:0] rd_addr_out,
    output logic              req,
    input  logic              rdy,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    input  logic              if_rdy,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [DATA_W-1:0] if_data,
    output logic              timeout,
    output logic              stray
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int AGE_W = $clog2(TIMEOUT+1);

    logic              cmd_v_q, cmd_v_d;
    logic [WORD_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [AGE_W-1:0]  age_q, age_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [WORD_W-1:0] rd_addr_out_q, rd_addr_out_d;
    logic              timeout_q, timeout_d;
    logic              stray_q, stray_d;

    logic [WORD_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_pop;
    logic              issue;
    logic              accept;
    logic              region_hit;
    logic              head_hit;
    logic              claim;
    logic              expire;
    logic [CNT_W-1:0]  outstanding;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_pending (
        .clk   (clk),
        .reset (reset),
        .push  (issue),
        .pop   (fifo_pop),
        .din   (cmd_addr_q),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Claim/timeout decode and handshake; issuing keeps outstanding
    // unchanged, so a new request needs a free slot beyond the current ones.
    always_comb begin
        region_hit  = if_rdy && (region_of(if_addr) == REGION);
        head_hit    = !fifo_empty && (if_addr[WORD_W-1:0] == fifo_head);
        claim       = region_hit && head_hit;
        expire      = !fifo_empty && !claim && (age_q == AGE_W'(TIMEOUT - 1));
        fifo_pop    = claim || expire;
        issue       = cmd_v_q && rdy && (!fifo_full || fifo_pop);
        outstanding = fifo_count + CNT_W'(cmd_v_q);
        rd_ack      = (!cmd_v_q || issue) && (outstanding < CNT_W'(DEPTH));
        accept      = rd_req && rd_ack;
        req         = cmd_v_q && !fifo_full;
    end

    // Next-state for command slot, head age and registered response outputs
    always_comb begin
        cmd_v_d    = cmd_v_q;
        cmd_addr_d = cmd_addr_q;
        if (accept) begin
            cmd_v_d    = 1'b1;
            cmd_addr_d = rd_addr;
        end else if (issue) begin
            cmd_v_d = 1'b0;
        end else begin
            cmd_v_d = cmd_v_q;
        end

        // The head is dropped on the edge where its age would reach TIMEOUT
        if (fifo_pop || (issue && fifo_empty)) begin
            age_d = AGE_W'(0);
        end else if (!fifo_empty) begin
            age_d = age_q + AGE_W'(1);
        end else begin
            age_d = AGE_W'(0);
        end

        rd_valid_d = claim;
        timeout_d  = expire;
        stray_d    = region_hit && !head_hit;
        if (claim) begin
            rd_data_d     = if_data;
            rd_addr_out_d = fifo_head;
        end else begin
            rd_data_d     = rd_data_q;
            rd_addr_out_d = rd_addr_out_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_v_q       <= 1'b0;
            cmd_addr_q    <= WORD_W'(0);
            age_q         <= AGE_W'(0);
            rd_valid_q    <= 1'b0;
            rd_data_q     <= DATA_W'(0);
            rd_addr_out_q <= WORD_W'(0);
            timeout_q     <= 1'b0;
            stray_q       <= 1'b0;
        end else begin
            cmd_v_q       <= cmd_v_d;
            cmd_addr_q    <= cmd_addr_d;
            age_q         <= age_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            rd_addr_out_q <= rd_addr_out_d;
            timeout_q     <= timeout_d;
            stray_q       <= stray_d;
        end
    end

    assign addr        = {REGION, cmd_addr_q};
    assign we          = 1'b0;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_addr_out = rd_addr_out_q;
    assign timeout     = timeout_q;
    assign stray       = stray_q;
endmodule

// File: tb/tb_sdram_read_port.sv
// Directed bench for sdram_read_port: expected returns go into a scoreboard
// queue, a negedge monitor checks every rd_valid and counts stray/timeout.
module tb_sdram_read_port;
    import sdram_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_req;
    logic [WORD_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [WORD_W-1:0] rd_addr_out;
    logic              req;
    logic              rdy;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              if_rdy;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_data;
    logic              timeout;
    logic              stray;

    always #5 clk = ~clk;

    sdram_read_port #(
        .DEPTH   (DEPTH),
        .REGION  (4'h0),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_addr_out (rd_addr_out),
        .req         (req),
        .rdy         (rdy),
        .addr        (addr),
        .we          (we),
        .if_rdy      (if_rdy),
        .if_addr     (if_addr),
        .if_data     (if_data),
        .timeout     (timeout),
        .stray       (stray)
    );

    int n_checks  = 0;
    int n_pass    = 0;
    int valid_cnt = 0;
    int stray_cnt = 0;
    int tmo_cnt   = 0;
    logic [35:0] sb_q [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [35:0] e;
        if (rd_valid === 1'b1) begin
            valid_cnt++;
            if (sb_q.size() == 0) begin
                check("rd_valid_unexpected", 64'(rd_valid), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check("rd_data", 64'(rd_data), 64'(e[15:0]));
                check("rd_addr_out", 64'(rd_addr_out), 64'(e[35:16]));
            end
        end
        if (stray === 1'b1) stray_cnt++;
        if (timeout === 1'b1) tmo_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_req = 1'b0;
        rdy    = 1'b0;
        if_rdy = 1'b0;
    endtask

    task automatic send_ret(input logic [23:0] a, input logic [15:0] d, input bit claim);
        if_rdy  = 1'b1;
        if_addr = a;
        if_data = d;
        if (claim) sb_q.push_back({a[19:0], d});
        cyc();
        if_rdy = 1'b0;
    endtask

    task automatic settle();
        cyc();
        cyc();
    endtask

    initial begin
        int s0, v0, t0, first;
        reset = 1'b1;
        idle();
        rd_addr = 20'h0;
        if_addr = 24'h0;
        if_data = 16'h0;
        repeat (2) cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rst_req", 64'(req), 64'(0));
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_timeout", 64'(timeout), 64'(0));
        check("rst_stray", 64'(stray), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        check("rst_rd_addr_out", 64'(rd_addr_out), 64'(0));
        check("rst_we", 64'(we), 64'(0));
        check("rst_rd_ack", 64'(rd_ack), 64'(1));

        // Single read
        cyc();
        rd_req  = 1'b1;
        rd_addr = 20'h00123;
        @(negedge clk);
        check("p1_ack", 64'(rd_ack), 64'(1));
        check("p1_req_idle", 64'(req), 64'(0));
        cyc();
        rd_req = 1'b0;
        rdy    = 1'b1;
        @(negedge clk);
        check("p1_req", 64'(req), 64'(1));
        check("p1_addr", 64'(addr), 64'(24'h000123));
        cyc();
        rdy = 1'b0;
        @(negedge clk);
        check("p1_req_cleared", 64'(req), 64'(0));
        repeat (4) cyc();
        v0 = valid_cnt;
        send_ret(24'h000123, 16'hBEEF, 1'b1);
        @(negedge clk);
        check("p1_valid_pulse", 64'(rd_valid), 64'(1));
        cyc();
        @(negedge clk);
        check("p1_valid_one_cycle", 64'(rd_valid), 64'(0));
        check("p1_valid_count", 64'(valid_cnt - v0), 64'(1));
        s0 = stray_cnt;
        send_ret(24'h000123, 16'hBEEF, 1'b0);
        settle();
        check("p1_fifo_empty_stray", 64'(stray_cnt - s0), 64'(1));

        // Back-to-back burst with rdy held high
        v0 = valid_cnt;
        rdy    = 1'b1;
        rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd_addr = 20'h00010 + 20'(i);
            @(negedge clk);
            check("burst_ack", 64'(rd_ack), 64'(i < 4));
            if (i > 0) check("burst_addr", 64'(addr), 64'(24'h000010 + 24'(i - 1)));
            cyc();
        end
        if_rdy  = 1'b1;
        if_addr = 24'h000010;
        if_data = 16'hA010;
        sb_q.push_back({20'h00010, 16'hA010});
        @(negedge clk);
        check("burst_full_ack", 64'(rd_ack), 64'(0));
        check("burst_full_req", 64'(req), 64'(0));
        cyc();
        if_rdy = 1'b0;
        @(negedge clk);
        check("burst_reack", 64'(rd_ack), 64'(1));
        cyc();
        rd_req = 1'b0;
        // Issue of 0x14 and claim of 0x11 in the same cycle
        if_rdy  = 1'b1;
        if_addr = 24'h000011;
        if_data = 16'hA011;
        sb_q.push_back({20'h00011, 16'hA011});
        @(negedge clk);
        check("simul_ack", 64'(rd_ack), 64'(0));
        check("simul_req", 64'(req), 64'(1));
        cyc();
        if_rdy = 1'b0;
        rdy    = 1'b0;
        @(negedge clk);
        check("simul_ack_after", 64'(rd_ack), 64'(1));
        check("simul_req_after", 64'(req), 64'(0));
        send_ret(24'h000012, 16'hA012, 1'b1);
        send_ret(24'h000013, 16'hA013, 1'b1);
        send_ret(24'h000014, 16'hA014, 1'b1);
        settle();
        check("burst_valid_count", 64'(valid_cnt - v0), 64'(5));
        s0 = stray_cnt;
        send_ret(24'h000014, 16'hA014, 1'b0);
        settle();
        check("burst_no_dup", 64'(stray_cnt - s0), 64'(1));

        // Foreign traffic
        rd_req  = 1'b1;
        rd_addr = 20'h00123;
        cyc();
        rd_req = 1'b0;
        rdy    = 1'b1;
        cyc();
        rdy = 1'b0;
        s0 = stray_cnt;
        v0 = valid_cnt;
        send_ret(24'hF00123, 16'h1111, 1'b0);
        send_ret(24'h000999, 16'h2222, 1'b0);
        settle();
        check("foreign_stray", 64'(stray_cnt - s0), 64'(1));
        check("foreign_no_claim", 64'(valid_cnt - v0), 64'(0));
        send_ret(24'h000123, 16'h5A5A, 1'b1);
        settle();
        check("foreign_genuine", 64'(valid_cnt - v0), 64'(1));

        // Timeout with no return
        rd_req  = 1'b1;
        rd_addr = 20'h00777;
        cyc();
        rd_req = 1'b0;
        rdy    = 1'b1;
        t0 = tmo_cnt;
        v0 = valid_cnt;
        first = 0;
        @(posedge clk);
        #1;
        rdy = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (timeout === 1'b1 && first == 0) first = e;
        end
        cyc();
        check("timeout_latency", 64'(first), 64'(15));
        check("timeout_count", 64'(tmo_cnt - t0), 64'(1));
        check("timeout_no_valid", 64'(valid_cnt - v0), 64'(0));
        s0 = stray_cnt;
        send_ret(24'h000777, 16'h7777, 1'b0);
        settle();
        check("timeout_fifo_empty", 64'(stray_cnt - s0), 64'(1));

        // Reset with three pending reads
        rdy    = 1'b1;
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr = 20'h00200 + 20'(i);
            cyc();
        end
        rd_req = 1'b0;
        cyc();
        rdy     = 1'b1;
        reset   = 1'b1;
        rd_req  = 1'b1;
        rd_addr = 20'h00300;
        if_rdy  = 1'b1;
        if_addr = 24'h000200;
        if_data = 16'hDEAD;
        cyc();
        reset = 1'b0;
        idle();
        @(negedge clk);
        check("mid_rst_rd_valid", 64'(rd_valid), 64'(0));
        check("mid_rst_stray", 64'(stray), 64'(0));
        check("mid_rst_timeout", 64'(timeout), 64'(0));
        check("mid_rst_req", 64'(req), 64'(0));
        check("mid_rst_rd_data", 64'(rd_data), 64'(0));
        check("mid_rst_rd_addr_out", 64'(rd_addr_out), 64'(0));
        check("mid_rst_rd_ack", 64'(rd_ack), 64'(1));
        cyc();
        s0 = stray_cnt;
        v0 = valid_cnt;
        send_ret(24'h000200, 16'hD200, 1'b0);
        send_ret(24'h000201, 16'hD201, 1'b0);
        send_ret(24'h000202, 16'hD202, 1'b0);
        settle();
        check("mid_rst_strays", 64'(stray_cnt - s0), 64'(3));
        check("mid_rst_no_valid", 64'(valid_cnt - v0), 64'(0));

        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
